// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-back data cache.
//   dcachef_t      : byte address split {tag, idx, bytoff}
//   dcache_frame_t : one cache frame {valid, dirty, tag, data}
//   dcache_state_t : controller states
package dcache_pkg;

  localparam int unsigned DTAG_W = 26;
  localparam int unsigned DIDX_W = 4;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    logic [31:0]       data;
  } dcache_frame_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    ALLOC,
    FLUSH,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// Bundle of the data cache signals: MEM-stage request side, memory
// controller side and the halt/flush handshake.
//   cache modport : the view of dcache itself
//   tb    modport : the view of a driver standing in for the pipeline + memory
interface dcache_if;
  logic        CLK;
  logic        RST;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport cache (
    input  CLK, RST, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport tb (
    output CLK, RST, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache, one word per frame.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   dmemREN/dmemWEN        MEM-stage read/write request (write wins if both)
//   dmemaddr, dmemstore    request byte address and store data
//   halt                   start flushing all dirty frames
//   dhit, dmemload         request satisfied this cycle, load data
//   flushed                flush finished (sticky until RST)
//   dREN/dWEN, daddr,
//   dstore, dload, dwait   memory controller handshake
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  dcache_frame_t     frames [SETS];
  dcache_state_t     state, nextState;
  logic [DIDX_W-1:0] flushIdx;

  dcachef_t      reqAddr;
  dcache_frame_t reqFrame;
  dcache_frame_t flushFrame;
  logic          req;
  logic          tagHit;
  logic          wrHit;
  logic          flushStep;
  logic          unusedBits;

  assign reqAddr    = dcachef_t'(dmemaddr);
  assign reqFrame   = frames[reqAddr.idx];
  assign flushFrame = frames[flushIdx];
  assign req        = dmemREN | dmemWEN;
  assign tagHit     = reqFrame.valid && (reqFrame.tag == reqAddr.tag);
  assign unusedBits = ^reqAddr.bytoff;

  always_comb begin
    nextState = state;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    wrHit     = 1'b0;
    flushStep = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending request always goes first; halt is only honoured when idle.
        if (req) begin
          if (tagHit) begin
            dhit  = 1'b1;
            wrHit = dmemWEN;
            if (!dmemWEN) dmemload = reqFrame.data;
          end else if (reqFrame.valid && reqFrame.dirty) begin
            nextState = WB;
          end else begin
            nextState = ALLOC;
          end
        end else if (halt) begin
          nextState = FLUSH;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {reqFrame.tag, reqAddr.idx, 2'b00};
        dstore = reqFrame.data;
        if (!dwait) nextState = ALLOC;
      end
      ALLOC: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) nextState = IDLE;
      end
      FLUSH: begin
        // Clean frames are skipped in one cycle without touching memory.
        if (flushFrame.valid && flushFrame.dirty) begin
          dWEN      = 1'b1;
          daddr     = {flushFrame.tag, flushIdx, 2'b00};
          dstore    = flushFrame.data;
          flushStep = !dwait;
        end else begin
          flushStep = 1'b1;
        end
        if (flushStep && (flushIdx == DIDX_W'(SETS - 1))) nextState = DONE;
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      flushIdx <= '0;
      for (int unsigned i = 0; i < SETS; i++) frames[i] <= '0;
    end else begin
      state <= nextState;
      if (wrHit) begin
        frames[reqAddr.idx].data  <= dmemstore;
        frames[reqAddr.idx].dirty <= 1'b1;
      end
      if ((state == ALLOC) && !dwait) begin
        frames[reqAddr.idx] <= '{valid: 1'b1, dirty: 1'b0, tag: reqAddr.tag, data: dload};
      end
      if ((state == IDLE) && (nextState == FLUSH)) begin
        flushIdx <= '0;
      end else if (flushStep) begin
        flushIdx                <= flushIdx + 1'b1;
        frames[flushIdx].dirty  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

  dcache_if bus();

  dcache #(.SETS(16)) dut (
    .CLK      (bus.CLK),
    .RST      (bus.RST),
    .dmemREN  (bus.dmemREN),
    .dmemWEN  (bus.dmemWEN),
    .dmemaddr (bus.dmemaddr),
    .dmemstore(bus.dmemstore),
    .halt     (bus.halt),
    .dhit     (bus.dhit),
    .dmemload (bus.dmemload),
    .flushed  (bus.flushed),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .dload    (bus.dload),
    .dwait    (bus.dwait)
  );

  initial bus.CLK = 1'b0;
  always #5 bus.CLK = ~bus.CLK;

  int compared = 0;
  int mismatched = 0;
  int forceWait = -1;

  // Reference: which word each set currently holds, plus backing memory and
  // the architectural (program-visible) memory image.
  logic        mValid [16];
  logic        mDirty [16];
  logic [29:0] mWord  [16];
  logic [31:0] mData  [16];
  logic [31:0] backMem [logic [29:0]];
  logic [31:0] archMem [logic [29:0]];
  logic [25:0] tagTab  [4];

  function automatic logic [31:0] seedVal(logic [29:0] w);
    return ({2'b01, w} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] backRd(logic [29:0] w);
    return backMem.exists(w) ? backMem[w] : seedVal(w);
  endfunction

  function automatic logic [31:0] archRd(logic [29:0] w);
    return archMem.exists(w) ? archMem[w] : backRd(w);
  endfunction

  function automatic int pickWait();
    if (forceWait >= 0) return forceWait;
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mWord[i]  = '0;
      mData[i]  = '0;
    end
    archMem.delete();
  endtask

  task automatic doReset();
    bus.RST = 1'b1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.halt = 1'b0;
    bus.dwait = 1'b0;
    @(negedge bus.CLK);
    @(negedge bus.CLK);
    bus.RST = 1'b0;
    modelReset();
  endtask

  // One MEM-stage request held until dhit, acting as the memory controller.
  task automatic doReq(bit wr, bit both, logic [31:0] addr, logic [31:0] sdata);
    logic [3:0]  idx   = addr[5:2];
    logic [29:0] w     = addr[31:2];
    bit          expHit = mValid[idx] && (mWord[idx] == w);
    bit          expWb  = !expHit && mValid[idx] && mDirty[idx];
    logic [29:0] vicW  = mWord[idx];
    logic [31:0] vicD  = mData[idx];
    int phase = 0, rem = 0, waitW = 0, waitA = 0, cyc = 0;
    bit done = 1'b0;
    bus.dmemREN   = !wr || both;
    bus.dmemWEN   = wr;
    bus.dmemaddr  = addr;
    bus.dmemstore = sdata;
    bus.dwait     = 1'b0;
    #1;
    check("hitNow", 32'(bus.dhit), 32'(expHit));
    while (!done && cyc < 200) begin
      if (bus.dhit) begin
        check("noMemOnHit", 32'({bus.dREN, bus.dWEN}), 32'(0));
        check("latency", 32'(cyc), 32'(expHit ? 0 : 1 + (expWb ? waitW + 1 : 0) + waitA + 1));
        if (wr) begin
          mData[idx]  = sdata;
          mDirty[idx] = 1'b1;
          archMem[w]  = sdata;
        end else begin
          check("loadData", bus.dmemload, archRd(w));
        end
        done = 1'b1;
      end else begin
        bus.dwait = 1'b0;
        if (bus.dWEN) begin
          if (phase != 1) begin
            phase = 1;
            rem = pickWait();
            waitW = rem;
            check("wbExpected", 32'(1), 32'(expWb));
          end
          check("wbAddr", bus.daddr, {vicW, 2'b00});
          check("wbData", bus.dstore, vicD);
          if (rem > 0) begin
            rem--;
            bus.dwait = 1'b1;
          end else begin
            backMem[vicW] = vicD;
            mDirty[idx] = 1'b0;
            phase = 0;
          end
        end else if (bus.dREN) begin
          if (phase != 2) begin
            phase = 2;
            rem = pickWait();
            waitA = rem;
          end
          check("allocAddr", bus.daddr, {w, 2'b00});
          bus.dload = backRd(w);
          if (rem > 0) begin
            rem--;
            bus.dwait = 1'b1;
          end else begin
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mWord[idx]  = w;
            mData[idx]  = backRd(w);
            phase = 0;
          end
        end
        @(negedge bus.CLK);
        #1;
        cyc++;
      end
    end
    check("reqDone", 32'(done), 32'(1));
    @(negedge bus.CLK);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic doFlush();
    int q[$];
    int nXfer, waits = 0, rem = 0, phase = 0, cur = 0, cyc = 0, seen = 0;
    for (int i = 0; i < 16; i++) if (mValid[i] && mDirty[i]) q.push_back(i);
    nXfer = q.size();
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.halt = 1'b1;
    bus.dwait = 1'b0;
    #1;
    while (!bus.flushed && cyc < 400) begin
      bus.dwait = 1'b0;
      if (bus.dWEN) begin
        if (phase == 0) begin
          phase = 1;
          seen++;
          rem = pickWait();
          waits += rem;
          check("flushQueued", 32'(q.size() > 0), 32'(1));
          cur = (q.size() > 0) ? q.pop_front() : 0;
        end
        check("flushAddr", bus.daddr, {mWord[cur], 2'b00});
        check("flushData", bus.dstore, mData[cur]);
        if (rem > 0) begin
          rem--;
          bus.dwait = 1'b1;
        end else begin
          backMem[mWord[cur]] = mData[cur];
          mDirty[cur] = 1'b0;
          phase = 0;
        end
      end
      @(negedge bus.CLK);
      #1;
      cyc++;
    end
    check("flushCycles", 32'(cyc), 32'(17 + waits));
    check("flushXfers", 32'(seen), 32'(nXfer));
    // Requests are ignored once the flush is complete.
    bus.halt = 1'b0;
    bus.dmemREN = 1'b1;
    bus.dmemaddr = {mWord[0], 2'b00};
    for (int k = 0; k < 4; k++) begin
      @(negedge bus.CLK);
      #1;
      check("doneFlushed", 32'(bus.flushed), 32'(1));
      check("doneNoHit", 32'(bus.dhit), 32'(0));
      check("doneNoMem", 32'({bus.dREN, bus.dWEN}), 32'(0));
    end
    bus.dmemREN = 1'b0;
    foreach (archMem[a]) check("memCoherent", backRd(a), archMem[a]);
  endtask

  initial begin
    logic [31:0] a;
    bit wr;
    tagTab[0] = 26'h0;
    tagTab[1] = 26'h1;
    tagTab[2] = 26'h2;
    tagTab[3] = 26'h3FF_FFFF;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    bus.dload = '0;
    doReset();
    #1;
    check("rstDhit", 32'(bus.dhit), 32'(0));
    check("rstLoad", bus.dmemload, 32'(0));
    check("rstFlushed", 32'(bus.flushed), 32'(0));
    check("rstDREN", 32'(bus.dREN), 32'(0));
    check("rstDWEN", 32'(bus.dWEN), 32'(0));
    check("rstDaddr", bus.daddr, 32'(0));
    check("rstDstore", bus.dstore, 32'(0));
    @(negedge bus.CLK);

    // Directed: cold read, write hit, conflict eviction, long ALLOC wait.
    forceWait = 0;
    backMem[30'h10] = 32'hDEAD_BEEF;
    doReq(1'b0, 1'b0, 32'h0000_0040, '0);
    doReq(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
    doReq(1'b0, 1'b0, 32'h0000_0040, '0);
    doReq(1'b0, 1'b0, 32'h0000_0080, '0);
    forceWait = 5;
    doReq(1'b0, 1'b0, 32'h0000_00C0, '0);
    forceWait = 0;
    doReq(1'b1, 1'b0, 32'h0000_00C3, 32'hCAFE_F00D);

    // Reset while a write-back is stalled.
    bus.dmemREN = 1'b1;
    bus.dmemaddr = 32'h0000_0100;
    bus.dwait = 1'b1;
    #1;
    check("rstWbMiss", 32'(bus.dhit), 32'(0));
    @(negedge bus.CLK);
    #1;
    check("rstWbActive", 32'(bus.dWEN), 32'(1));
    check("rstWbAddr", bus.daddr, 32'h0000_00C0);
    bus.RST = 1'b1;
    @(negedge bus.CLK);
    bus.RST = 1'b0;
    #1;
    check("rstWbDWEN", 32'(bus.dWEN), 32'(0));
    check("rstWbDREN", 32'(bus.dREN), 32'(0));
    bus.dmemREN = 1'b0;
    bus.dwait = 1'b0;
    modelReset();
    @(negedge bus.CLK);
    doReq(1'b0, 1'b0, 32'h0000_00C0, '0);

    // Random traffic over a few tags so hits, clean and dirty misses all occur.
    forceWait = -1;
    for (int n = 0; n < 300; n++) begin
      a = {tagTab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      wr = ($urandom_range(0, 1) == 1);
      doReq(wr, wr && ($urandom_range(0, 7) == 0), a, $urandom);
    end
    doFlush();

    // Directed flush: only frames 0 and 15 dirty.
    doReset();
    @(negedge bus.CLK);
    forceWait = 0;
    doReq(1'b1, 1'b0, 32'h0000_0000, 32'h0BAD_0000);
    doReq(1'b1, 1'b0, 32'h0000_003C, 32'h0BAD_003C);
    forceWait = -1;
    doFlush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
